// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS front end.
//   WORD_W        : architectural word width (32 bits)
//   fetch_entry_t : one fetched instruction, {pc, instr}, 64 bits packed
package mips_pkg;

    localparam int WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage : mips_pkg

// File: rtl/fq_mem.sv
// fq_mem -- storage array for fetch_queue: DEPTH entries of fetch_entry_t,
// one synchronous write port and one asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : entry to write
//   raddr : read index
//   rdata : entry at raddr, combinational
module fq_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t  rdata
);

    fetch_entry_t mem [DEPTH];

    // NOTE: the array has no reset; entries are only read once the pointers
    // say they were written, so clearing them would cost logic for nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fq_mem

// File: rtl/fetch_queue.sv
// fetch_queue -- FIFO between instruction fetch and decode.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : fetch-side handshake, in_pc/in_instr the offer
//   out_valid/out_ready  : decode-side handshake, out_pc/out_instr the head
//   flush                : redirect, discards every queued entry
//   count                : current occupancy (0..DEPTH)
// Build option: define FETCH_QUEUE_BYPASS_EN to let an offer into an empty
// queue appear on the out_* ports in the same cycle.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_pc,
    input  logic [WORD_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_instr,
    input  logic              out_ready,
    input  logic              flush,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    fetch_entry_t  rd_entry;
    fetch_entry_t  wr_entry;
    logic          stored_valid;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          rd_adv;

    assign stored_valid = (count_q != '0);
    // A full queue refuses offers even if decode drains it this cycle, so
    // in_ready never depends on out_ready.
    assign in_ready     = !reset && (count_q < FULL_COUNT);
    assign wr_entry     = '{pc: in_pc, instr: in_instr};

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = !stored_valid && in_valid && !flush && !reset;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        out_valid = !reset && !flush && stored_valid;
        out_pc    = rd_entry.pc;
        out_instr = rd_entry.instr;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass_hit) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    // A bypassed entry consumed at once never touches storage; one not
    // consumed is stored and becomes the head next cycle.
    assign wr_en  = push && !(bypass_hit && out_ready);
    assign rd_adv = pop && !bypass_hit;
`else
    assign wr_en  = push;
    assign rd_adv = pop;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            // AW-bit pointers wrap modulo DEPTH on their own.
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_adv})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;

    fq_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(wr_entry),
        .raddr(rd_ptr),
        .rdata(rd_entry)
    );

endmodule : fetch_queue

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter AW, default 2, the pointer width; AW equals log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the fetch side offers an instruction.
REQ-006 SHALL have port in_pc, input, 32, the PC of the offered instruction.
REQ-007 SHALL have port in_instr, input, 32, the offered instruction word.
REQ-008 SHALL have port in_ready, output, 1, meaning the queue accepts the offer this cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning a head entry is presented to decode.
REQ-010 SHALL have port out_pc, output, 32, the PC of the head entry.
REQ-011 SHALL have port out_instr, output, 32, the instruction word of the head entry.
REQ-012 SHALL have port out_ready, input, 1, meaning decode consumes the head this cycle.
REQ-013 SHALL have port flush, input, 1, the branch/jump redirect that discards all queued entries.
REQ-014 SHALL have port count, output, AW+1, the current occupancy.

Function
REQ-015 SHALL push, storing {in_pc, in_instr} at the tail, when in_valid and in_ready and not flush.
REQ-016 SHALL pop, advancing the head, when out_valid and out_ready and not flush.
REQ-017 SHALL drive in_ready = (count < DEPTH) and not reset; a full queue SHALL NOT accept a push even when a pop occurs the same cycle.
REQ-018 SHALL hold count unchanged on a simultaneous push and pop when 0 < count < DEPTH.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH with no gap or duplicate entry.
REQ-020 SHALL, when flush=1, set count to 0 and both pointers to 0 at the next edge, ignoring that cycle's push and pop.
REQ-021 SHALL force out_valid=0 combinationally while flush=1.
REQ-022 SHALL present out_pc and out_instr from storage with out_valid = (count != 0), absent bypass.
REQ-023 SHALL keep out_pc and out_instr stable while out_valid=1 and out_ready=0.
REQ-024 SHALL deliver entries in push order, without loss, with a minimum latency of one cycle from push to out_valid, absent bypass.
REQ-025 SHALL leave out_pc and out_instr as don't-care whenever out_valid=0.

Reset
REQ-026 SHALL, while reset=1 at an edge, clear count, the read pointer and the write pointer to 0.
REQ-027 SHALL hold out_valid=0 and in_ready=0 while reset is asserted; reset has priority over flush, push and pop.
REQ-028 SHALL not clear the storage array on reset.
REQ-029 SHALL present in_ready=1, out_valid=0 and count=0 on the first cycle after reset.

Configuration
REQ-030 SHALL, with macro FETCH_QUEUE_BYPASS_EN defined, pass a push directly through when count=0 and in_valid=1 and not flush: out_valid=1 and out_pc/out_instr=in_pc/in_instr in the same cycle.
REQ-031 SHALL, with bypass active, store the entry only if out_ready=0; if out_ready=1, count stays 0.
REQ-032 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from the in_* ports to the out_* ports.

Structure
REQ-033 SHALL take the 32-bit word width and the {pc, instr} entry type from the shared package mips_pkg.
REQ-034 SHALL implement storage in one sub-module, fq_mem: DEPTH x 64 bits, one synchronous write port and one asynchronous read port.
REQ-035 SHALL keep the pointer, count and handshake logic in fetch_queue itself.

Verification
REQ-036 SHALL cover: reset, then push pc=0x3000 instr=0x3C01_1234 -> out_valid=1 next cycle with the same values, count=1.
REQ-037 SHALL cover: 4 pushes with out_ready=0 -> count=4, in_ready=0; a 5th offer is not accepted; then pops return 0x3000, 0x3004, 0x3008, 0x300C in order.
REQ-038 SHALL cover: count=2 with push and pop in the same cycle -> count stays 2, with order preserved across pointer wrap over 10 entries.
REQ-039 SHALL cover: count=3 and flush=1 together with in_valid=1 -> count=0 next cycle, out_valid=0 during flush, and the flushed-cycle entry never appears.
REQ-040 SHALL cover: reset asserted mid-stream with count=3 -> count=0, out_valid=0, and the first new push 0x4000 is output first.
REQ-041 SHALL cover, with FETCH_QUEUE_BYPASS_EN: an empty queue with push 0x5000 and out_ready=1 -> out_valid=1 the same cycle, and count stays 0.
